// File: rtl/cpu_instr_seq.sv
// cpu_instr_seq: instruction fetch/decode/sequencer with program counter and branch evaluation
module cpu_instr_seq #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       Din,
  output logic              done,
  output logic              RW,
  output logic [ADDR_W-1:0] Address,
  output logic [15:0]       Dout,
  input  logic [15:0]       dp_addr,
  input  logic [15:0]       dp_store_data,
  input  logic              flag_z,
  input  logic              flag_n,
  input  logic              flag_o,
  output logic [3:0]        alu_op,
  output logic [2:0]        sel_a,
  output logic [2:0]        sel_b,
  output logic [2:0]        wr_addr,
  output logic [15:0]       imm,
  output logic [1:0]        wb_src,
  output logic              wr_en,
  output logic [15:0]       load_data
);
  typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  state_t state, next_state;
  logic [ADDR_W-1:0] pc, fa, br_target;
  logic [15:0] ir;
  logic [3:0] op;
  logic is_alu, is_ldi, is_ld, is_st, is_br, taken;
  assign op        = ir[15:12];
  assign is_alu    = op <= 4'd6;
  assign is_ldi    = op == 4'hA;
  assign is_ld     = op == 4'h8;
  assign is_st     = op == 4'h9;
  assign is_br     = op[3:2] == 2'b11;
  assign taken     = (op == 4'hC && flag_z) || (op == 4'hD && flag_n) || (op == 4'hE && flag_o) || op == 4'hF;
  assign br_target = fa + {{(ADDR_W-12){ir[11]}}, ir[11:0]};
  // state register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RST;
    else state <= next_state;
  end
  // fetch capture, PC update, branch redirect and load data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      fa <= RESET_PC;
      ir <= '0;
      load_data <= '0;
    end else begin
      if (state == S_FETCH) begin
        ir <= Din;
        fa <= pc;
        pc <= pc + 1'b1;
      end
      if (state == S_EXEC && is_br && taken) pc <= br_target;
      if (state == S_MEM && is_ld) load_data <= Din;
    end
  end
  // next-state sequencing: memory ops take the MEM detour, loads also WB
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_RST:    next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC:   next_state = (is_ld || is_st) ? S_MEM : S_FETCH;
      S_MEM:    next_state = is_ld ? S_WB : S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end
  // bus and datapath strobes decoded from state and the held instruction
  always_comb begin
    done    = state == S_FETCH;
    RW      = !(state == S_MEM && is_st);
    Address = state == S_MEM ? dp_addr[ADDR_W-1:0] : pc;
    Dout    = (state == S_MEM && is_st) ? dp_store_data : 16'h0000;
    wr_en   = (state == S_EXEC && (is_alu || is_ldi)) || state == S_WB;
    wb_src  = state == S_WB ? 2'd2 : (state == S_EXEC && is_ldi) ? 2'd1 : 2'd0;
    alu_op  = op;
    sel_a   = ir[8:6];
    sel_b   = ir[5:3];
    wr_addr = ir[11:9];
    imm     = {7'b0, ir[8:0]};
  end
endmodule

// File: tb/tb_cpu_instr_seq.sv
// tb_cpu_instr_seq: randomized instruction stream checked cycle by cycle against an instruction-timeline model
module tb_cpu_instr_seq;
  logic clk = 0, reset = 1;
  logic [15:0] Din = 0, Dout, dp_addr = 0, dp_store_data = 0, imm, load_data, Address;
  logic flag_z = 0, flag_n = 0, flag_o = 0, done, RW, wr_en;
  logic [3:0] alu_op;
  logic [2:0] sel_a, sel_b, wr_addr;
  logic [1:0] wb_src;
  int checks = 0, passed = 0;
  logic [15:0] m_pc = 0, m_ld = 0;

  cpu_instr_seq dut (.clk(clk), .reset(reset), .Din(Din), .done(done), .RW(RW), .Address(Address),
    .Dout(Dout), .dp_addr(dp_addr), .dp_store_data(dp_store_data), .flag_z(flag_z), .flag_n(flag_n),
    .flag_o(flag_o), .alu_op(alu_op), .sel_a(sel_a), .sel_b(sel_b), .wr_addr(wr_addr), .imm(imm),
    .wb_src(wb_src), .wr_en(wr_en), .load_data(load_data));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_done"}, 16'(done), 16'h0);
    chk({tag, "_RW"}, 16'(RW), 16'h1);
    chk({tag, "_wr_en"}, 16'(wr_en), 16'h0);
    chk({tag, "_wb_src"}, 16'(wb_src), 16'h0);
    chk({tag, "_Dout"}, Dout, 16'h0);
    chk({tag, "_Address"}, Address, 16'h0000);
    chk({tag, "_load_data"}, load_data, 16'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 0;
    #1;
    chk_idle("rst_cycle");
    m_pc = 0;
    m_ld = 0;
  endtask

  // one instruction: cycle 0 is the fetch, 3/4/5 cycles total for plain/ST/LD
  task automatic run_instr(input logic [15:0] instr, input logic fz, fn, fo,
                           input logic [15:0] dpa, sd, ldd, input int abort_k);
    logic [3:0] op;
    logic [15:0] pc0;
    logic tk;
    int n;
    op = instr[15:12];
    pc0 = m_pc;
    n = op == 4'h8 ? 5 : op == 4'h9 ? 4 : 3;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      Din = 16'($urandom);
      dp_addr = 16'($urandom);
      dp_store_data = 16'($urandom);
      {flag_z, flag_n, flag_o} = 3'($urandom);
      if (k == 0) Din = instr;
      if (k == 2) {flag_z, flag_n, flag_o} = {fz, fn, fo};
      if (k == 3) begin
        dp_addr = dpa;
        dp_store_data = sd;
        Din = ldd;
      end
      if (k == abort_k) begin
        reset = 1;
        #1;
        chk_idle("abort");
        m_pc = 0;
        m_ld = 0;
        return;
      end
      #1;
      if (k == 4) m_ld = ldd;
      chk("done", 16'(done), 16'(k == 0));
      chk("RW", 16'(RW), 16'(!(op == 4'h9 && k == 3)));
      chk("Address", Address, k == 3 ? dpa : k == 0 ? pc0 : pc0 + 16'd1);
      chk("Dout", Dout, (op == 4'h9 && k == 3) ? sd : 16'h0);
      chk("wr_en", 16'(wr_en), 16'((k == 2 && (op <= 4'd6 || op == 4'hA)) || k == 4));
      chk("wb_src", 16'(wb_src), k == 4 ? 16'd2 : (k == 2 && op == 4'hA) ? 16'd1 : 16'd0);
      chk("load_data", load_data, m_ld);
      if (k > 0) begin
        chk("alu_op", 16'(alu_op), 16'(op));
        chk("sel_a", 16'(sel_a), 16'(instr[8:6]));
        chk("sel_b", 16'(sel_b), 16'(instr[5:3]));
        chk("wr_addr", 16'(wr_addr), 16'(instr[11:9]));
        chk("imm", imm, 16'(instr[8:0]));
      end
    end
    tk = (op == 4'hC && fz) || (op == 4'hD && fn) || (op == 4'hE && fo) || op == 4'hF;
    m_pc = tk ? pc0 + {{4{instr[11]}}, instr[11:0]} : pc0 + 16'd1;
  endtask

  task automatic pin(input string name, input logic [15:0] exp);
    @(posedge clk);
    #1;
    chk({name, "_model_pc"}, m_pc, exp);
    chk({name, "_Address"}, Address, exp);
    chk({name, "_done"}, 16'(done), 16'h1);
  endtask

  task automatic run_rand();
    run_instr(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom), -1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk_idle("in_reset");
    release_reset();
    run_instr(16'h1298, 0, 0, 0, 0, 0, 0, -1);
    pin("sub", 16'h0001);
    run_instr(16'hABFF, 0, 0, 0, 0, 0, 0, -1);
    pin("ldi", 16'h0002);
    chk("ldi_imm", imm, 16'h01FF);
    chk("ldi_wr_addr", 16'(wr_addr), 16'h5);
    run_instr(16'h8840, 0, 0, 0, 16'h0100, 0, 16'hBEEF, -1);
    pin("ld", 16'h0003);
    chk("ld_load_data", load_data, 16'hBEEF);
    run_instr(16'h9050, 0, 0, 0, 16'h0020, 16'h1234, 0, -1);
    pin("st", 16'h0004);
    run_instr(16'hF00C, 0, 0, 0, 0, 0, 0, -1);
    pin("bra_fwd", 16'h0010);
    run_instr(16'hCFFE, 1, 0, 0, 0, 0, 0, -1);
    pin("brz_taken", 16'h000E);
    run_instr(16'hF002, 0, 0, 0, 0, 0, 0, -1);
    run_instr(16'hCFFE, 0, 1, 1, 0, 0, 0, -1);
    pin("brz_not_taken", 16'h0011);
    run_instr(16'hFFEE, 0, 0, 0, 0, 0, 0, -1);
    pin("bra_back", 16'hFFFF);
    run_instr(16'hF7FF, 0, 0, 0, 0, 0, 0, -1);
    pin("bra_wrap", 16'h07FE);
    for (int i = 0; i < 400; i++) run_rand();
    run_instr(16'h9050, 0, 0, 0, 16'h0020, 16'h5555, 0, 3);
    release_reset();
    run_instr(16'h8840, 0, 0, 0, 16'h0040, 0, 16'hCAFE, 4);
    release_reset();
    run_instr(16'h0000, 0, 0, 0, 0, 0, 0, 2);
    release_reset();
    for (int i = 0; i < 200; i++) run_rand();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/cpu_instr_seq.md
Name: cpu_instr_seq

Overview:
- Instruction fetch/decode/sequencer at the CPU end of the 16-bit instruction bus.
- Raises done when it can accept a word on Din, captures it, decodes the opcode/register/immediate/offset fields and sequences datapath and memory strobes over 3-5 cycles.
- Holds the program counter and evaluates branches against datapath flags.

Parameters:
- ADDR_W, 16, width of PC/Address.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- Din  in  16  instruction word (FETCH) / load data (MEM of LD).
- done  out  1  high only in FETCH: ready to capture next instruction.
- RW  out  1  1=read, 0=write (low only in ST MEM cycle).
- Address  out  ADDR_W  PC in FETCH; dp_addr in MEM; else PC.
- Dout  out  16  dp_store_data during ST MEM, else 0.
- dp_addr  in  16  datapath value of R[first] (LD/ST address).
- dp_store_data  in  16  datapath value of R[second] (ST data).
- flag_z, flag_n, flag_o  in  1 each  datapath flags.
- alu_op  out  4  opcode of current instruction (valid DECODE..WB).
- sel_a, sel_b, wr_addr  out  3 each  fields IR[8:6], IR[5:3], IR[11:9].
- imm  out  16  zero-extended IR[8:0].
- wb_src  out  2  0=ALU, 1=imm, 2=load data.
- wr_en  out  1  one-cycle register-file write strobe.
- load_data  out  16  Din captured in LD MEM cycle.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 MOV, 7 NOP, 8 LD, 9 ST, A LDI, B reserved (=NOP), C BRZ, D BRN, E BRO, F BRA.
- Reset (async):
  - state=RST, PC=RESET_PC, IR=0.
  - done=0, RW=1, wr_en=0, Dout=0, load_data=0, wb_src=0, Address=RESET_PC.
- States: RST, FETCH, DECODE, EXEC, MEM, WB.
- RST: one cycle after reset deassert, then FETCH.
- FETCH: done=1, Address=PC, RW=1. At rising edge: IR<=Din, FA<=PC, PC<=PC+1 (wraps mod 2^ADDR_W) -> DECODE.
- DECODE: fields driven from IR -> EXEC.
- EXEC:
  - opcode 0-6: wr_en=1, wb_src=0 -> FETCH.
  - LDI: wr_en=1, wb_src=1 -> FETCH.
  - 7, B: no strobe -> FETCH.
  - LD / ST: -> MEM.
  - Branch: taken if C&flag_z, D&flag_n, E&flag_o, or F. If taken, PC<=FA+sext(IR[11:0]), wrapping. -> FETCH.
  - Flags are sampled in the EXEC cycle only.
- MEM:
  - LD: Address=dp_addr, RW=1, load_data<=Din -> WB.
  - ST: Address=dp_addr, RW=0, Dout=dp_store_data -> FETCH.
- WB (LD only): wr_en=1, wb_src=2 -> FETCH.
- Latency (FETCH-to-FETCH): ALU/MOV/NOT/LDI/NOP/branch 3 cycles; ST 4; LD 5.
- done is low in every non-FETCH state; Din is ignored outside FETCH and the LD MEM cycle.
- Reset mid-instruction: abort immediately; no wr_en and no RW=0 may be issued after reset asserts.

Test Plan:
- Reset then release -> done=0 for exactly 1 cycle after release, then done=1, Address=0x0000.
- Din=0x1298 (SUB R1,R2,R3) at PC 0 -> done low 2 cycles, then in EXEC: alu_op=1, wr_addr=1, sel_a=2, sel_b=3, wr_en=1; next FETCH Address=0x0001.
- LDI R5,#0x1FF (Din=0xABFF) -> wr_en with wb_src=1, imm=0x01FF, wr_addr=5; 3-cycle latency.
- LD R4,[R1] (0x8840), dp_addr=0x0100, Din=0xBEEF in MEM -> Address=0x0100, RW=1, then WB: wr_en=1, wb_src=2, load_data=0xBEEF; 5-cycle latency.
- ST (0x9050), dp_addr=0x0020, dp_store_data=0x1234 -> one cycle RW=0, Address=0x0020, Dout=0x1234; 4-cycle latency.
- BRZ offset 0xFFE at FA=0x0010: with flag_z=1 -> next Address=0x000E; with flag_z=0 -> 0x0011. BRA offset 0x7FF at FA=0xFFFF -> PC wraps to 0x07FE.
